// File: rtl/clock_pkg.sv
// Shared clock constants, ms-to-cycle conversion and the
// auto-repeat state encoding for the button front end.
package clock_pkg;

  localparam int CLK_HZ_DEF = 50_000_000;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  function automatic int ms_to_cycles(
    input int hz,
    input int ms
  );
    return hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, counting debouncer and
// registered rising-edge press pulse.
module btn_debounce #(
  parameter int DB_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic lvl,
  output logic pulse
);

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic          s1;
  logic          s2;
  logic          lvl_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
      pulse <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= lvl;
      pulse <= lvl & ~lvl_d;
      // any bounce back to the accepted level restarts the window
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYC - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Five-button conditioner: debounced levels and press pulses;
// up/down auto-repeat when BTN_AUTO_REPEAT_EN is defined.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int CLK_HZ          = CLK_HZ_DEF,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic start,
  output logic up_lvl,
  output logic down_lvl,
  output logic left_lvl,
  output logic right_lvl,
  output logic start_lvl
);

  localparam int DB_CYC = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int RD_CYC =
    ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
  localparam int RR_CYC =
    ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);

  if (DB_CYC < 1 || RD_CYC < 1 || RR_CYC < 1) begin : gen_cfg_err
    $error("button_conditioner: cycle counts must be >= 1");
  end

  logic [4:0] raw;
  logic [4:0] lvl;
  logic [4:0] press;
  logic [4:0] pulse;

  assign raw = {btn_start, btn_right, btn_left,
                btn_down, btn_up};

  for (genvar i = 0; i < 5; i++) begin : gen_btn
    btn_debounce #(
      .DB_CYC (DB_CYC)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .lvl   (lvl[i]),
      .pulse (press[i])
    );
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RMAX = (RD_CYC > RR_CYC) ? RD_CYC : RR_CYC;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [1:0] rpt;
  logic       both;

  // holding up and down together is treated as a conflict
  assign both = lvl[0] & lvl[1];

  for (genvar g = 0; g < 2; g++) begin : gen_rpt
    rpt_state_t    st;
    rpt_state_t    st_n;
    logic [RW-1:0] cnt;
    logic [RW-1:0] cnt_n;
    logic          fire;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st  <= RPT_IDLE;
        cnt <= '0;
      end else begin
        st  <= st_n;
        cnt <= cnt_n;
      end
    end

    always_comb begin
      st_n  = st;
      cnt_n = cnt;
      fire  = 1'b0;
      if (!lvl[g] || both) begin
        st_n  = RPT_IDLE;
        cnt_n = '0;
      end else begin
        unique case (st)
          RPT_IDLE: begin
            if (press[g]) begin
              st_n  = RPT_DELAY;
              cnt_n = '0;
            end
          end
          RPT_DELAY: begin
            if (cnt == RW'(RD_CYC - 1)) begin
              fire  = 1'b1;
              st_n  = RPT_REPEAT;
              cnt_n = '0;
            end else begin
              cnt_n = cnt + RW'(1);
            end
          end
          RPT_REPEAT: begin
            if (cnt == RW'(RR_CYC - 1)) begin
              fire  = 1'b1;
              cnt_n = '0;
            end else begin
              cnt_n = cnt + RW'(1);
            end
          end
          default: begin
            st_n  = RPT_IDLE;
            cnt_n = '0;
          end
        endcase
      end
    end

    assign rpt[g] = fire;
  end

  assign pulse = press | {3'b000, rpt};
`else
  assign pulse = press;
`endif

  assign up        = pulse[0];
  assign down      = pulse[1];
  assign left      = pulse[2];
  assign right     = pulse[3];
  assign start     = pulse[4];
  assign up_lvl    = lvl[0];
  assign down_lvl  = lvl[1];
  assign left_lvl  = lvl[2];
  assign right_lvl = lvl[3];
  assign start_lvl = lvl[4];

endmodule
